harmonic_engine: RTL and testbench
==================================

Name: harmonic_engine

Overview:
Parametrised additive-synthesis core. On each sample tick it sums up to NUM_HARMONICS sine partials of a fundamental frequency, each partial scaled by a linearly decaying amplitude. Per-harmonic phases are held internally. Partials at or above Nyquist and partials with zero amplitude are skipped. The block drives an external registered sine LUT and produces one saturated signed sample per tick for the DAC path. It replaces the fixed 7-harmonic loop in the top level.

Parameters:
NUM_HARMONICS, 8, size of the phase store and the maximum number of partials
PHASE_MOD, 48000, phase wrap modulus (sample rate)
PHASE_BITS, 16, phase register width
PHASE_SHIFT, 5, right shift from phase to LUT address (48000>>5 gives 1500 entries)
LUT_ADDR_BITS, 11, LUT address width
LUT_LATENCY, 2, cycles from lut_addr to a valid lut_value
AMP_BITS, 8, unsigned amplitude width
ACC_BITS, 32, accumulator width
OUT_BITS, 16, output sample width
OUT_SHIFT, 0, arithmetic right shift applied before saturation

Ports:
fpga_clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_tick  in  1  single-cycle pulse that starts a sample computation
frequency  in  PHASE_BITS  fundamental phase increment per sample
harmonic_count  in  8  number of partials requested; values above NUM_HARMONICS are clamped
amp_start  in  AMP_BITS  amplitude of the fundamental
amp_step  in  AMP_BITS  amplitude decrement per harmonic
phase_sync  in  1  sampled with sample_tick; zeroes all phases before the update
lut_addr  out  LUT_ADDR_BITS  sine LUT address
lut_value  in  16  signed LUT data
sample_out  out  OUT_BITS  signed summed sample
sample_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  high while a computation is in progress
overrun  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Reset: all phases 0, state IDLE, lut_addr 0, sample_out 0, sample_valid 0, busy 0, overrun 0, accumulator 0. A reset mid-computation aborts it; no sample_valid is produced.
- States: IDLE, INIT, HARM, LUT_WAIT, MAC, DONE.
- IDLE: on sample_tick, latch frequency, clamped harmonic_count, amp_start, amp_step and phase_sync, then go to INIT.
- INIT (1 cycle):
  - n=0, inc=frequency, amp=amp_start, accumulator=0.
  - If phase_sync is latched, clear all phases.
  - If count=0, go to DONE; otherwise go to HARM.
- HARM (1 cycle per harmonic n):
  - A harmonic is muted if inc >= PHASE_MOD/2 or amp == 0.
  - Muted: phase[n] is held, no LUT access, no MAC. Go straight to the next-harmonic step.
  - Active: new = phase[n] + inc; if new >= PHASE_MOD, subtract PHASE_MOD once. Write new to phase[n]. Drive lut_addr = new >> PHASE_SHIFT. Go to LUT_WAIT.
- LUT_WAIT: hold for LUT_LATENCY cycles, then go to MAC.
- MAC (1 cycle):
  - product = lut_value (signed) × amp (zero-extended), arithmetic shift right by AMP_BITS.
  - product is sign-extended and added to the accumulator, which wraps at ACC_BITS.
  - Then the next-harmonic step.
- Next-harmonic step:
  - n += 1, inc += frequency in a PHASE_BITS+8 bit register with no wrap.
  - amp = max(0, amp − amp_step), saturating at 0.
  - If n == count, go to DONE; otherwise go to HARM.
- DONE (1 cycle):
  - sample_out = saturate(acc >>> OUT_SHIFT) to the signed OUT_BITS range.
  - sample_valid = 1, then return to IDLE.
- Latency: with A active and M muted harmonics, sample_valid is high exactly 2 + A·(LUT_LATENCY+2) + M cycles after the tick cycle.
- busy is high from the cycle after the tick through DONE inclusive.
- A tick while busy is ignored and pulses overrun for 1 cycle; the computation in progress is unaffected.
- A tick in the same cycle as DONE counts as an overrun.
- Phases of harmonics at index ≥ count are left unchanged.
- sample_out holds its value between updates.

Test Plan:
(Configuration: NUM_HARMONICS=8, LUT_LATENCY=2, PHASE_MOD=48000, PHASE_SHIFT=5, LUT model.)
1. Basic timing: freq=1000, count=1, amp 255/0, one tick -> lut_addr=31, phase[0]=1000, sample_valid 6 cycles after the tick, busy high for cycles 1–6.
2. Phase wrap: freq=20000, count=1, three ticks -> phase[0] = 20000, 40000, 12000; lut_addr = 625, 1250, 375.
3. Nyquist mute: freq=7000, count=8 -> harmonics 0–2 active with addrs 218, 437, 656; harmonics 3–7 muted with phases held at 0; sample_valid at cycle 19.
4. Amplitude decay: LUT constant 1000, freq=100, count=4, amp 200/100 -> amps 200, 100, 0, 0; sample_out = 781+390 = 1171; sample_valid at cycle 12.
5. Overrun and sync: second tick at cycle 3 -> overrun pulse at cycle 3, first result unchanged. Then a tick with phase_sync=1, freq=500 -> every active phase[n] = (n+1)·500.
6. Saturation and reset: LUT constant 32767, count=8, amp 255/0, freq=100 -> sample_out=32767. A reset asserted at cycle 5 of the next computation -> no sample_valid, all phases 0, sample_out 0.

Source files
------------

// File: rtl/harmonic_engine.sv
// harmonic_engine -- additive-synthesis core.
//
// On each sample tick, sums up to NUM_HARMONICS sine partials of a fundamental.
// Partial n runs at (n+1)*frequency. Its amplitude starts at amp_start and drops
// by amp_step for each harmonic, saturating at zero. Each partial keeps its own
// phase, wrapped at PHASE_MOD. A partial is skipped (muted, phase held) when its
// increment is at or above Nyquist or its amplitude is zero. The sine comes from
// an external registered LUT with LUT_LATENCY cycles of read latency.
//
// Ports:
//   fpga_clock     in   system clock
//   reset          in   asynchronous, active-high reset
//   sample_tick    in   single-cycle pulse starting a sample computation
//   frequency      in   fundamental phase increment per sample
//   harmonic_count in   partials requested (clamped to NUM_HARMONICS)
//   amp_start      in   amplitude of the fundamental (unsigned)
//   amp_step       in   amplitude decrement per harmonic
//   phase_sync     in   sampled with sample_tick; zeroes all phases first
//   lut_addr       out  sine LUT address
//   lut_value      in   signed LUT data, valid LUT_LATENCY cycles after lut_addr
//   sample_out     out  signed, saturated sum; held between updates
//   sample_valid   out  one-cycle pulse while sample_out carries a new sample
//   busy           out  high from the cycle after the tick through DONE
//   overrun        out  high in any cycle where a tick arrives while busy
module harmonic_engine #(
    parameter int NUM_HARMONICS = 8,
    parameter int PHASE_MOD     = 48000,
    parameter int PHASE_BITS    = 16,
    parameter int PHASE_SHIFT   = 5,
    parameter int LUT_ADDR_BITS = 11,
    parameter int LUT_LATENCY   = 2,
    parameter int AMP_BITS      = 8,
    parameter int ACC_BITS      = 32,
    parameter int OUT_BITS      = 16,
    parameter int OUT_SHIFT     = 0
) (
    input  logic                        fpga_clock,
    input  logic                        reset,
    input  logic                        sample_tick,
    input  logic [PHASE_BITS-1:0]       frequency,
    input  logic [7:0]                  harmonic_count,
    input  logic [AMP_BITS-1:0]         amp_start,
    input  logic [AMP_BITS-1:0]         amp_step,
    input  logic                        phase_sync,
    output logic [LUT_ADDR_BITS-1:0]    lut_addr,
    input  logic signed [15:0]          lut_value,
    output logic [OUT_BITS-1:0]         sample_out,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int INC_BITS = PHASE_BITS + 8;
    localparam int IDX_BITS = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
    localparam int PW       = 16 + AMP_BITS + 1;

    localparam logic [7:0]            NH8       = 8'(NUM_HARMONICS);
    localparam logic [7:0]            WAIT_LAST = 8'(LUT_LATENCY - 1);
    localparam logic [INC_BITS-1:0]   NYQUIST   = INC_BITS'(PHASE_MOD / 2);
    localparam logic [PHASE_BITS:0]   MOD_W     = (PHASE_BITS + 1)'(PHASE_MOD);

    localparam logic signed [ACC_BITS-1:0] SAT_MAX =
        {{(ACC_BITS - OUT_BITS + 1){1'b0}}, {(OUT_BITS - 1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN =
        {{(ACC_BITS - OUT_BITS + 1){1'b1}}, {(OUT_BITS - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_HARM,
        S_LUT_WAIT,
        S_MAC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Request latched at the tick
    logic [PHASE_BITS-1:0]  r_freq;
    logic [7:0]             r_count;
    logic [AMP_BITS-1:0]    r_amp_start;
    logic [AMP_BITS-1:0]    r_amp_step;
    logic                   r_sync;

    // Per-harmonic walk
    logic [7:0]             r_n;
    logic [INC_BITS-1:0]    r_inc;
    logic [AMP_BITS-1:0]    r_amp;
    logic [7:0]             r_wait;
    logic signed [ACC_BITS-1:0] r_acc;

    logic [PHASE_BITS-1:0]  r_phase [NUM_HARMONICS];

    logic [LUT_ADDR_BITS-1:0] r_lut_addr;
    logic [OUT_BITS-1:0]      r_sample_out;
    logic                     r_sample_valid;

    logic [IDX_BITS-1:0]      w_idx;
    logic                     w_muted;
    logic [PHASE_BITS:0]      w_phase_sum;
    logic [PHASE_BITS-1:0]    w_phase_new;
    logic [7:0]               w_n_next;
    logic                     w_last;
    logic [INC_BITS-1:0]      w_inc_next;
    logic [AMP_BITS-1:0]      w_amp_next;
    logic [7:0]               w_count_clamped;

    logic signed [PW-1:0]       w_lut_ext;
    logic signed [PW-1:0]       w_amp_ext;
    logic signed [PW-1:0]       w_prod;
    logic signed [PW-1:0]       w_prod_sh;
    logic signed [ACC_BITS-1:0] w_prod_acc;
    logic signed [ACC_BITS-1:0] w_acc_next;
    logic signed [ACC_BITS-1:0] w_acc_sh;
    logic [OUT_BITS-1:0]        w_sat;

    assign w_idx   = r_n[IDX_BITS-1:0];
    assign w_muted = (r_inc >= NYQUIST) || (r_amp == '0);

    // An active increment is below PHASE_MOD/2, so its low PHASE_BITS bits hold it
    // exactly and one conditional subtraction is enough to wrap.
    assign w_phase_sum = {1'b0, r_phase[w_idx]} + {1'b0, r_inc[PHASE_BITS-1:0]};
    assign w_phase_new = (w_phase_sum >= MOD_W) ? PHASE_BITS'(w_phase_sum - MOD_W)
                                                : PHASE_BITS'(w_phase_sum);

    assign w_n_next   = r_n + 8'd1;
    assign w_last     = (w_n_next == r_count);
    assign w_inc_next = r_inc + {8'b0, r_freq};
    assign w_amp_next = (r_amp > r_amp_step) ? (r_amp - r_amp_step) : '0;

    assign w_count_clamped = (harmonic_count > NH8) ? NH8 : harmonic_count;

    // Signed LUT sample times zero-extended amplitude, scaled back by AMP_BITS.
    assign w_lut_ext  = {{(AMP_BITS + 1){lut_value[15]}}, lut_value};
    assign w_amp_ext  = {{17{1'b0}}, r_amp};
    assign w_prod     = w_lut_ext * w_amp_ext;
    assign w_prod_sh  = w_prod >>> AMP_BITS;
    assign w_prod_acc = {{(ACC_BITS - PW){w_prod_sh[PW-1]}}, w_prod_sh};

    always_comb begin
        w_acc_next = r_acc;
        case (r_state)
            S_INIT:  w_acc_next = '0;
            S_MAC:   w_acc_next = r_acc + w_prod_acc;
            default: w_acc_next = r_acc;
        endcase
    end

    // The output register is loaded on the edge that enters DONE from the
    // accumulator's next value, so sample_valid and sample_out line up in DONE.
    assign w_acc_sh = w_acc_next >>> OUT_SHIFT;

    always_comb begin
        w_sat = w_acc_sh[OUT_BITS-1:0];
        if (w_acc_sh > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_BITS-1:0];
        end else if (w_acc_sh < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_BITS-1:0];
        end
    end

    always_ff @(posedge fpga_clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (sample_tick) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_state_next = (r_count == 8'd0) ? S_DONE : S_HARM;
            end
            S_HARM: begin
                if (w_muted) begin
                    w_state_next = w_last ? S_DONE : S_HARM;
                end else begin
                    w_state_next = S_LUT_WAIT;
                end
            end
            S_LUT_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                w_state_next = w_last ? S_DONE : S_HARM;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge fpga_clock or posedge reset) begin
        if (reset) begin
            r_freq      <= '0;
            r_count     <= '0;
            r_amp_start <= '0;
            r_amp_step  <= '0;
            r_sync      <= 1'b0;
            r_n         <= '0;
            r_inc       <= '0;
            r_amp       <= '0;
            r_wait      <= '0;
            r_acc       <= '0;
            r_lut_addr  <= '0;
            for (int unsigned i = 0; i < NUM_HARMONICS; i++) begin
                r_phase[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sample_tick) begin
                        r_freq      <= frequency;
                        r_count     <= w_count_clamped;
                        r_amp_start <= amp_start;
                        r_amp_step  <= amp_step;
                        r_sync      <= phase_sync;
                    end
                end
                S_INIT: begin
                    r_n   <= '0;
                    r_inc <= {8'b0, r_freq};
                    r_amp <= r_amp_start;
                    r_acc <= w_acc_next;
                    if (r_sync) begin
                        for (int unsigned i = 0; i < NUM_HARMONICS; i++) begin
                            r_phase[i] <= '0;
                        end
                    end
                end
                S_HARM: begin
                    if (w_muted) begin
                        r_n   <= w_n_next;
                        r_inc <= w_inc_next;
                        r_amp <= w_amp_next;
                    end else begin
                        r_phase[w_idx] <= w_phase_new;
                        r_lut_addr     <= LUT_ADDR_BITS'(w_phase_new >> PHASE_SHIFT);
                        r_wait         <= '0;
                    end
                end
                S_LUT_WAIT: begin
                    r_wait <= r_wait + 8'd1;
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_n   <= w_n_next;
                    r_inc <= w_inc_next;
                    r_amp <= w_amp_next;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clock or posedge reset) begin
        if (reset) begin
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_state_next == S_DONE && r_state != S_DONE) begin
                r_sample_out   <= w_sat;
                r_sample_valid <= 1'b1;
            end
        end
    end

    assign lut_addr     = r_lut_addr;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = sample_tick && (r_state != S_IDLE);

endmodule

// File: tb/tb_harmonic_engine.sv
// Directed bench for harmonic_engine with a scoreboard. Each tick pushes the
// hand-computed sample, final LUT address and latency. A monitor pops an entry
// and compares it whenever sample_valid is seen. The LUT model is registered,
// with two cycles of latency. It returns either the address itself or a constant.
module tb_harmonic_engine;

    logic               fpga_clock = 1'b0;
    logic               reset = 1'b1;
    logic               sample_tick = 1'b0;
    logic [15:0]        frequency = '0;
    logic [7:0]         harmonic_count = '0;
    logic [7:0]         amp_start = '0;
    logic [7:0]         amp_step = '0;
    logic               phase_sync = 1'b0;
    logic [10:0]        lut_addr;
    logic signed [15:0] lut_value = '0;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    harmonic_engine #(
        .NUM_HARMONICS(8),
        .PHASE_MOD(48000),
        .PHASE_BITS(16),
        .PHASE_SHIFT(5),
        .LUT_ADDR_BITS(11),
        .LUT_LATENCY(2),
        .AMP_BITS(8),
        .ACC_BITS(32),
        .OUT_BITS(16),
        .OUT_SHIFT(0)
    ) dut (
        .fpga_clock(fpga_clock),
        .reset(reset),
        .sample_tick(sample_tick),
        .frequency(frequency),
        .harmonic_count(harmonic_count),
        .amp_start(amp_start),
        .amp_step(amp_step),
        .phase_sync(phase_sync),
        .lut_addr(lut_addr),
        .lut_value(lut_value),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 fpga_clock = ~fpga_clock;

    int cyc = 0;
    always @(posedge fpga_clock) cyc <= cyc + 1;

    // LUT model: mode 0 returns the address, mode 1 returns lut_const
    logic               lut_mode = 1'b0;
    logic signed [15:0] lut_const = '0;
    logic signed [15:0] lut_s1 = '0;
    always @(posedge fpga_clock) begin
        lut_s1    <= lut_mode ? lut_const : $signed({5'b0, lut_addr});
        lut_value <= lut_s1;
    end

    typedef struct {
        string name;
        int    sample;
        int    addr;
        int    lat;
        int    tick_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare every presented sample against the oldest expectation
    always @(negedge fpga_clock) begin
        exp_t e;
        if (!reset && sample_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_sample"}, longint'($signed(sample_out)), e.sample);
                chk({e.name, "_addr"}, longint'(lut_addr), e.addr);
                chk({e.name, "_latency"}, cyc - e.tick_cyc, e.lat);
            end
        end
    end

    task automatic set_req(input int f, input int c, input int as, input int ast,
                           input bit s);
        frequency      = 16'(f);
        harmonic_count = 8'(c);
        amp_start      = 8'(as);
        amp_step       = 8'(ast);
        phase_sync     = s;
    endtask

    task automatic push_exp(input string name, input int s, input int a, input int l);
        exp_t e;
        e.name = name; e.sample = s; e.addr = a; e.lat = l; e.tick_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 300) begin
            @(posedge fpga_clock); #1;
            k++;
        end
        if (k >= 300) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic do_vec(input string name, input int f, input int c, input int as,
                          input int ast, input bit s, input int es, input int ea,
                          input int el);
        @(posedge fpga_clock); #1;
        set_req(f, c, as, ast, s);
        sample_tick = 1'b1;
        push_exp(name, es, ea, el);
        @(posedge fpga_clock); #1;
        sample_tick = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge fpga_clock);
        @(negedge fpga_clock);
        chk("rst_sample_out", longint'(sample_out), 0);
        chk("rst_sample_valid", longint'(sample_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_lut_addr", longint'(lut_addr), 0);
        @(posedge fpga_clock); #1;
        reset = 1'b0;

        // 1. Basic timing with busy profile: 1000>>5 = 31, (31*255)>>8 = 30
        lut_mode = 1'b0;
        @(posedge fpga_clock); #1;
        set_req(1000, 1, 255, 0, 1'b1);
        sample_tick = 1'b1;
        push_exp("basic", 30, 31, 6);
        for (int i = 0; i < 8; i++) begin
            @(negedge fpga_clock);
            chk($sformatf("basic_busy_c%0d", i), longint'(busy),
                (i >= 1 && i <= 6) ? 1 : 0);
            @(posedge fpga_clock); #1;
            sample_tick = 1'b0;
        end
        wait_idle("basic");

        // 2. Phase wrap: 20000, 40000, 12000
        do_vec("wrap0", 20000, 1, 255, 0, 1'b1, 622, 625, 6);
        do_vec("wrap1", 20000, 1, 255, 0, 1'b0, 1245, 1250, 6);
        do_vec("wrap2", 20000, 1, 255, 0, 1'b0, 373, 375, 6);

        // 3. Nyquist mute: harmonics 0-2 active, 3-7 muted; clamp; count 0
        do_vec("nyq", 7000, 8, 255, 0, 1'b1, 217 + 435 + 653, 656, 19);
        do_vec("clamp", 7000, 255, 255, 0, 1'b1, 1305, 656, 19);
        do_vec("count0", 1000, 0, 255, 0, 1'b0, 0, 656, 2);

        // 4. Amplitude decay: amps 200,100,0,0 -> 781 + 390
        lut_mode = 1'b1; lut_const = 16'sd1000;
        do_vec("decay", 100, 4, 200, 100, 1'b1, 1171, 6, 12);
        // Negative LUT values: (-1000*255)>>>8 = -997 per partial
        lut_const = -16'sd1000;
        do_vec("neg", 100, 2, 255, 0, 1'b1, -1994, 6, 10);

        // 5. Overrun: second tick at cycle 3 is ignored
        lut_mode = 1'b0;
        @(posedge fpga_clock); #1;
        set_req(1000, 1, 255, 0, 1'b1);
        sample_tick = 1'b1;
        push_exp("ovr_first", 30, 31, 6);
        @(posedge fpga_clock); #1;
        sample_tick = 1'b0;
        @(posedge fpga_clock); #1;
        @(posedge fpga_clock); #1;
        set_req(5000, 3, 255, 0, 1'b0);
        sample_tick = 1'b1;
        @(negedge fpga_clock);
        chk("ovr_pulse", longint'(overrun), 1);
        @(posedge fpga_clock); #1;
        sample_tick = 1'b0;
        @(negedge fpga_clock);
        chk("ovr_clear", longint'(overrun), 0);
        wait_idle("ovr_first");
        // Sync: phases 500, 1000, 1500 -> addrs 15, 31, 46 -> 14 + 30 + 45
        do_vec("sync", 500, 3, 255, 0, 1'b1, 89, 46, 14);

        // 6. Saturation, both rails: (32767*255)>>8 = 32638, x8 saturates
        lut_mode = 1'b1; lut_const = 16'sd32767;
        do_vec("sat_pos", 100, 8, 255, 0, 1'b1, 32767, 25, 34);
        lut_const = -16'sd32768;
        do_vec("sat_neg", 100, 8, 255, 0, 1'b1, -32768, 25, 34);

        // Reset at cycle 5 of a computation aborts it
        lut_const = 16'sd32767;
        @(posedge fpga_clock); #1;
        set_req(100, 8, 255, 0, 1'b0);
        sample_tick = 1'b1;
        @(posedge fpga_clock); #1;
        sample_tick = 1'b0;
        repeat (4) begin
            @(posedge fpga_clock); #1;
        end
        reset = 1'b1;
        @(posedge fpga_clock); #1;
        reset = 1'b0;
        @(negedge fpga_clock);
        chk("abort_sample_out", longint'(sample_out), 0);
        chk("abort_lut_addr", longint'(lut_addr), 0);
        chk("abort_busy", longint'(busy), 0);
        repeat (40) @(posedge fpga_clock);
        #1;
        // Phases are zero after reset, so no sync is needed for addr 31
        lut_mode = 1'b0;
        do_vec("post_rst", 1000, 1, 255, 0, 1'b0, 30, 31, 6);

        repeat (5) @(posedge fpga_clock);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
